// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: bundles the instruction-RAM handshake, sequencer
// controls and the per-cycle control strobes of instr_sequencer.
//   master : instruction source / CPU control (drives instr_valid,
//            instruction, stall, resume; observes state and strobes)
//   slave  : the sequencer itself
// Fields: instr_valid, instruction[IW], stall, resume, state[2],
//   encoded_opcode[OPC_W], exec_idx[4], last_cycle, ir_en, pc_cnt_en,
//   pc_sload, ram_wren_data, mul_busy, halted, illegal.
// With INSTR_SEQ_IRQ_EN defined: irq, irq_mask (to sequencer), irq_ack.
interface instr_sequencer_if #(
  parameter int IW    = 16,
  parameter int OPC_W = 6
);
  logic             instr_valid;
  logic [IW-1:0]    instruction;
  logic             stall;
  logic             resume;
  logic [1:0]       state;
  logic [OPC_W-1:0] encoded_opcode;
  logic [3:0]       exec_idx;
  logic             last_cycle;
  logic             ir_en;
  logic             pc_cnt_en;
  logic             pc_sload;
  logic             ram_wren_data;
  logic             mul_busy;
  logic             halted;
  logic             illegal;
`ifdef INSTR_SEQ_IRQ_EN
  logic             irq;
  logic             irq_mask;
  logic             irq_ack;

  modport master (
    output instr_valid, instruction, stall, resume, irq, irq_mask,
    input  state, encoded_opcode, exec_idx, last_cycle, ir_en, pc_cnt_en,
           pc_sload, ram_wren_data, mul_busy, halted, illegal, irq_ack
  );
  modport slave (
    input  instr_valid, instruction, stall, resume, irq, irq_mask,
    output state, encoded_opcode, exec_idx, last_cycle, ir_en, pc_cnt_en,
           pc_sload, ram_wren_data, mul_busy, halted, illegal, irq_ack
  );
`else
  modport master (
    output instr_valid, instruction, stall, resume,
    input  state, encoded_opcode, exec_idx, last_cycle, ir_en, pc_cnt_en,
           pc_sload, ram_wren_data, mul_busy, halted, illegal
  );
  modport slave (
    input  instr_valid, instruction, stall, resume,
    output state, encoded_opcode, exec_idx, last_cycle, ir_en, pc_cnt_en,
           pc_sload, ram_wren_data, mul_busy, halted, illegal
  );
`endif
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/execute sequencer with instruction register.
// Sizes each instruction's execute phase by class (1, 2 or MUL_CYCLES
// cycles) and emits per-cycle strobes for PC, IR and data RAM, with
// stall, halt/resume and illegal-opcode handling.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - instr_sequencer_if.slave (handshake, controls, strobes)
// Optional feature: define INSTR_SEQ_IRQ_EN to add irq/irq_mask/irq_ack
// and the one-cycle IRQ state (state 3).
module instr_sequencer #(
  parameter int IW         = 16,
  parameter int OPC_W      = 6,
  parameter int MUL_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2,
    S_IRQ   = 2'd3
  } state_t;

  localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);

  state_t        st;
  logic [IW-1:0] ir;
  logic [3:0]    idx;

  // Instruction class decode from the held instruction register
  logic [3:0] t;
  logic [1:0] sub;
  logic       z;
  logic       b;
  logic [3:0] last_idx;
  logic       wr_at0, wr_at1, ld_at0, ld_at1;
  logic       is_ill, is_stp, is_mul;

  assign t   = ir[IW-1 -: 4];
  assign sub = ir[IW-5 -: 2];
  assign z   = (ir[IW-5 -: 7] == '0);
  assign b   = ir[IW-12];

  always_comb begin
    last_idx = '0;
    wr_at0   = 1'b0;
    wr_at1   = 1'b0;
    ld_at0   = 1'b0;
    ld_at1   = 1'b0;
    is_ill   = 1'b0;
    is_stp   = 1'b0;
    is_mul   = 1'b0;
    case (t)
      4'b0110: begin
        last_idx = 4'd1;
        wr_at1   = (sub == 2'b00) || (sub == 2'b11);
      end
      4'b1000, 4'b1001: begin
        last_idx = MUL_LAST;
        is_mul   = 1'b1;
      end
      4'b1010, 4'b1011: is_ill = 1'b1;
      4'b1100: ld_at0 = 1'b1;
      4'b1101: begin
        last_idx = 4'd1;
        wr_at0   = 1'b1;
        ld_at1   = 1'b1;
      end
      4'b1110: last_idx = 4'd1;
      4'b1111: begin
        if (!z) begin
          is_ill = 1'b1;
        end else if (b) begin
          is_stp = 1'b1;
        end else begin
          last_idx = 4'd1;
          ld_at1   = 1'b1;
        end
      end
      default: last_idx = '0;
    endcase
  end

  logic irq_take;
`ifdef INSTR_SEQ_IRQ_EN
  assign irq_take = bus.irq && !bus.irq_mask;
`else
  assign irq_take = 1'b0;
`endif

  logic at_last;
  assign at_last = (idx == last_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= S_FETCH;
      ir  <= '0;
      idx <= '0;
    end else if (!bus.stall) begin
      case (st)
        S_FETCH: begin
          if (bus.instr_valid) begin
            ir  <= bus.instruction;
            idx <= '0;
            st  <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (at_last) begin
            idx <= '0;
            if (is_stp)        st <= S_HALT;
            else if (irq_take) st <= S_IRQ;
            else               st <= S_FETCH;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        S_HALT: begin
          if (irq_take)        st <= S_IRQ;
          else if (bus.resume) st <= S_FETCH;
        end
        S_IRQ: st <= S_FETCH;
        default: st <= S_FETCH;
      endcase
    end
  end

  // Strobes are combinational; rst_n is folded in so nothing can fire
  // while reset is held, even though FETCH would otherwise accept.
  logic go;
  logic in_exec;
  assign go      = rst_n && !bus.stall;
  assign in_exec = (st == S_EXEC);

  logic fetch_acc;
  assign fetch_acc = go && (st == S_FETCH) && bus.instr_valid;

  assign bus.state          = st;
  assign bus.encoded_opcode = ir[IW-1 -: OPC_W];
  assign bus.exec_idx       = idx;
  assign bus.last_cycle     = in_exec && at_last;
  assign bus.ir_en          = fetch_acc;
  assign bus.pc_cnt_en      = fetch_acc;
  assign bus.pc_sload       = go && ((in_exec && ((ld_at0 && idx == 4'd0) ||
                                                  (ld_at1 && idx == 4'd1))) ||
                                     (st == S_IRQ));
  assign bus.ram_wren_data  = go && ((in_exec && ((wr_at0 && idx == 4'd0) ||
                                                  (wr_at1 && idx == 4'd1))) ||
                                     (st == S_IRQ));
  assign bus.mul_busy       = go && in_exec && is_mul;
  assign bus.illegal        = go && in_exec && is_ill && (idx == 4'd0);
  assign bus.halted         = (st == S_HALT);
`ifdef INSTR_SEQ_IRQ_EN
  assign bus.irq_ack        = go && (st == S_IRQ);
`endif

  // Operand bits of the IR belong to the datapath; only the opcode is used here.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: two instances (MUL_CYCLES=4 and
// MUL_CYCLES=1) share stimulus; a per-instruction behavioural model
// predicts every output each cycle, and directed literal checks pin the
// model on the documented scenarios.
module tb_instr_sequencer;
  localparam int IW    = 16;
  localparam int OPC_W = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv, stl, res;
  logic [15:0] ins;
  logic        irq_i, irq_mask_i;

  always #5 clk = ~clk;

  instr_sequencer_if #(.IW(IW), .OPC_W(OPC_W)) b0 ();
  instr_sequencer_if #(.IW(IW), .OPC_W(OPC_W)) b1 ();

  assign b0.instr_valid = iv;  assign b1.instr_valid = iv;
  assign b0.instruction = ins; assign b1.instruction = ins;
  assign b0.stall       = stl; assign b1.stall       = stl;
  assign b0.resume      = res; assign b1.resume      = res;
`ifdef INSTR_SEQ_IRQ_EN
  assign b0.irq = irq_i;       assign b1.irq = irq_i;
  assign b0.irq_mask = irq_mask_i; assign b1.irq_mask = irq_mask_i;
`endif

  instr_sequencer #(.IW(IW), .OPC_W(OPC_W), .MUL_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(b0));
  instr_sequencer #(.IW(IW), .OPC_W(OPC_W), .MUL_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1));

  typedef struct packed {
    logic [1:0] state;
    logic [5:0] opc;
    logic [3:0] idx;
    logic last, ir_en, pc_cnt_en, sload, wren, mul, halted, ill, ack;
  } obs_t;

  obs_t act0, act1;
  logic ack0, ack1;
`ifdef INSTR_SEQ_IRQ_EN
  assign ack0 = b0.irq_ack; assign ack1 = b1.irq_ack;
`else
  assign ack0 = 1'b0;       assign ack1 = 1'b0;
`endif
  assign act0 = {b0.state, b0.encoded_opcode, b0.exec_idx, b0.last_cycle, b0.ir_en,
                 b0.pc_cnt_en, b0.pc_sload, b0.ram_wren_data, b0.mul_busy,
                 b0.halted, b0.illegal, ack0};
  assign act1 = {b1.state, b1.encoded_opcode, b1.exec_idx, b1.last_cycle, b1.ir_en,
                 b1.pc_cnt_en, b1.pc_sload, b1.ram_wren_data, b1.mul_busy,
                 b1.halted, b1.illegal, ack1};

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Per-instruction profile straight from the class table: cycle count,
  // exec index of each RAM-write / PC-load strobe (-1 = none), flags.
  function automatic void profile(input logic [15:0] w, input int mc, output int n,
                                  output int wr_at, output int ld_at,
                                  output bit ill, output bit stp, output bit mul);
    int t;
    t = int'(w[15:12]);
    n = 1; wr_at = -1; ld_at = -1; ill = 0; stp = 0; mul = 0;
    if (t <= 5 || t == 7) n = 1;
    else if (t == 6) begin
      n = 2;
      if (w[11:10] == 2'b00 || w[11:10] == 2'b11) wr_at = 1;
    end
    else if (t == 8 || t == 9) begin n = mc; mul = 1; end
    else if (t == 10 || t == 11) ill = 1;
    else if (t == 12) ld_at = 0;
    else if (t == 13) begin n = 2; wr_at = 0; ld_at = 1; end
    else if (t == 14) n = 2;
    else if (w[11:5] != 7'd0) ill = 1;
    else if (w[4]) stp = 1;
    else begin n = 2; ld_at = 1; end
  endfunction

  // Model state per instance: 0 fetch, 1 exec, 2 halt, 3 irq
  int          m_st [2];
  logic [15:0] m_ir [2];
  int          m_idx[2];
  int          mulc [2];
  bit          run = 0;

  always @(negedge clk) begin
    if (run) begin
      for (int k = 0; k < 2; k++) begin
        obs_t e, a;
        int n, wr_at, ld_at;
        bit ill, stp, mul, go, take;
        e = '0;
        a = (k == 0) ? act0 : act1;
        n = 1; wr_at = -1; ld_at = -1; ill = 0; stp = 0; mul = 0;
        go = !stl;
`ifdef INSTR_SEQ_IRQ_EN
        take = irq_i && !irq_mask_i;
`else
        take = 0;
`endif
        if (!rst_n) begin
          m_st[k] = 0; m_ir[k] = '0; m_idx[k] = 0;
        end else begin
          e.state = 2'(m_st[k]);
          e.opc   = m_ir[k][15:10];
          e.idx   = 4'(m_idx[k]);
          case (m_st[k])
            0: begin
              e.ir_en = iv && go; e.pc_cnt_en = iv && go;
            end
            1: begin
              profile(m_ir[k], mulc[k], n, wr_at, ld_at, ill, stp, mul);
              e.last  = (m_idx[k] == n - 1);
              e.wren  = go && (m_idx[k] == wr_at);
              e.sload = go && (m_idx[k] == ld_at);
              e.ill   = go && ill && (m_idx[k] == 0);
              e.mul   = go && mul;
            end
            2: e.halted = 1'b1;
            default: begin
              e.ack = go; e.sload = go; e.wren = go;
            end
          endcase
        end
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL model u%0d t=%0t: got st=%0d opc=%h idx=%0d strobes=%b, expected st=%0d opc=%h idx=%0d strobes=%b",
                   k, $time, a.state, a.opc, a.idx, a[8:0], e.state, e.opc, e.idx, e[8:0]);
        end
        if (rst_n && go) begin
          case (m_st[k])
            0: if (iv) begin m_ir[k] = ins; m_idx[k] = 0; m_st[k] = 1; end
            1: begin
              if (m_idx[k] == n - 1) begin
                m_idx[k] = 0;
                m_st[k] = stp ? 2 : (take ? 3 : 0);
              end else m_idx[k]++;
            end
            2: begin
              if (take) m_st[k] = 3;
              else if (res) m_st[k] = 0;
            end
            default: m_st[k] = 0;
          endcase
        end
      end
    end
  end

  task automatic drive(input bit v, input logic [15:0] w, input bit s, input bit r);
    @(posedge clk); #1;
    iv = v; ins = w; stl = s; res = r;
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] w;
    w = 16'($urandom);
    if (w[15:12] == 4'hF && ($urandom % 2) == 0) w[11:5] = '0;
    return w;
  endfunction

  initial begin
    int c_wr, c_ld, i_wr, i_ld, cnt4, cnt1, li4, li1;
    mulc[0] = 4; mulc[1] = 1;
    for (int k = 0; k < 2; k++) begin m_st[k] = 0; m_ir[k] = '0; m_idx[k] = 0; end
    rst_n = 0; iv = 0; ins = '0; stl = 0; res = 0; irq_i = 0; irq_mask_i = 0;
    run = 1;

    // Reset holds strobes low even with a valid instruction present
    drive(1, 16'h4000, 0, 0); @(negedge clk);
    chk("reset ir_en", int'(b0.ir_en), 0);
    chk("reset state", int'(b0.state), 0);
    chk("reset halted", int'(b0.halted), 0);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("add c0 ir_en", int'(b0.ir_en), 1);
    chk("add c0 pc_cnt_en", int'(b0.pc_cnt_en), 1);
    drive(0, '0, 0, 0); @(negedge clk);
    chk("add c1 state", int'(b0.state), 1);
    chk("add c1 idx", int'(b0.exec_idx), 0);
    chk("add c1 last", int'(b0.last_cycle), 1);
    drive(0, '0, 0, 0); @(negedge clk);
    chk("add c2 state", int'(b0.state), 0);

    // PUSH writes on idx1
    drive(1, 16'h6000, 0, 0); @(negedge clk);
    drive(0, '0, 0, 0); @(negedge clk);
    chk("push idx0 wren", int'(b0.ram_wren_data), 0);
    drive(0, '0, 0, 0); @(negedge clk);
    chk("push idx1 wren", int'(b0.ram_wren_data), 1);
    chk("push idx1 last", int'(b0.last_cycle), 1);
    drive(0, '0, 0, 0); @(negedge clk);
    chk("push after state", int'(b0.state), 0);

    // POP never writes
    drive(1, 16'h6800, 0, 0); @(negedge clk);
    drive(0, '0, 0, 0); @(negedge clk);
    chk("pop idx0 wren", int'(b0.ram_wren_data), 0);
    drive(0, '0, 0, 0); @(negedge clk);
    chk("pop idx1 wren", int'(b0.ram_wren_data), 0);

    // MUL with 4 and 1 execute cycles
    drive(1, 16'h8000, 0, 0); @(negedge clk);
    cnt4 = 0; cnt1 = 0; li4 = -1; li1 = -1;
    for (int i = 0; i < 6; i++) begin
      drive(0, '0, 0, 0); @(negedge clk);
      cnt4 += int'(b0.mul_busy); cnt1 += int'(b1.mul_busy);
      if (b0.last_cycle) li4 = int'(b0.exec_idx);
      if (b1.last_cycle) li1 = int'(b1.exec_idx);
    end
    chk("mul4 busy cycles", cnt4, 4);
    chk("mul4 last idx", li4, 3);
    chk("mul1 busy cycles", cnt1, 1);
    chk("mul1 last idx", li1, 0);

    // CALL with 3 stalled cycles at idx0
    drive(1, 16'hD123, 0, 0); @(negedge clk);
    c_wr = 0; c_ld = 0; i_wr = -1; i_ld = -1;
    for (int i = 0; i < 6; i++) begin
      drive(0, '0, (i < 3), 0); @(negedge clk);
      if (i < 3) chk("call stalled idx", int'(b0.exec_idx), 0);
      if (b0.ram_wren_data) begin c_wr++; i_wr = i; end
      if (b0.pc_sload) begin c_ld++; i_ld = int'(b0.exec_idx); end
    end
    chk("call wren count", c_wr, 1);
    chk("call wren cycle", i_wr, 3);
    chk("call sload count", c_ld, 1);
    chk("call sload idx", i_ld, 1);

    // STP, ignored fetch while halted, resume
    drive(1, 16'hF010, 0, 0); @(negedge clk);
    drive(0, '0, 0, 0); @(negedge clk);
    chk("stp last", int'(b0.last_cycle), 1);
    drive(1, 16'h4000, 0, 0); @(negedge clk);
    chk("halt state", int'(b0.state), 2);
    chk("halt halted", int'(b0.halted), 1);
    chk("halt ir_en", int'(b0.ir_en), 0);
    drive(1, 16'h4000, 0, 0); @(negedge clk);
    chk("halt holds", int'(b0.state), 2);
    drive(0, '0, 0, 1); @(negedge clk);
    chk("resume cycle state", int'(b0.state), 2);
    drive(0, '0, 0, 0); @(negedge clk);
    chk("after resume state", int'(b0.state), 0);
    chk("after resume halted", int'(b0.halted), 0);

    // Illegal F030
    drive(1, 16'hF030, 0, 0); @(negedge clk);
    drive(0, '0, 0, 0); @(negedge clk);
    chk("illegal pulse", int'(b0.illegal), 1);
    chk("illegal sload", int'(b0.pc_sload), 0);
    drive(0, '0, 0, 0); @(negedge clk);
    chk("illegal back", int'(b0.state), 0);
    chk("illegal clears", int'(b0.illegal), 0);

`ifdef INSTR_SEQ_IRQ_EN
    drive(1, 16'h4000, 0, 0); @(negedge clk);
    irq_i = 1;
    drive(0, '0, 0, 0); @(negedge clk);
    chk("irq exec last", int'(b0.last_cycle), 1);
    irq_i = 0;
    drive(0, '0, 0, 0); @(negedge clk);
    chk("irq state", int'(b0.state), 3);
    chk("irq ack", int'(b0.irq_ack), 1);
    chk("irq sload", int'(b0.pc_sload), 1);
    chk("irq wren", int'(b0.ram_wren_data), 1);
    drive(0, '0, 0, 0); @(negedge clk);
    chk("irq to fetch", int'(b0.state), 0);
    irq_i = 1; irq_mask_i = 1;
    drive(1, 16'h4000, 0, 0); @(negedge clk);
    drive(0, '0, 0, 0); @(negedge clk);
    drive(0, '0, 0, 0); @(negedge clk);
    chk("masked irq state", int'(b0.state), 0);
    irq_i = 0; irq_mask_i = 0;
`endif

    // Randomised phase, including mid-instruction resets
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      iv  = ($urandom % 2) == 0;
      ins = rand_instr();
      stl = ($urandom % 5) == 0;
      res = ($urandom % 8) == 0;
`ifdef INSTR_SEQ_IRQ_EN
      irq_i = ($urandom % 6) == 0;
      irq_mask_i = ($urandom % 3) == 0;
`endif
      if (!rst_n) rst_n = 1;
      else if (($urandom % 400) == 0) rst_n = 0;
    end
    @(posedge clk); #1;
    @(negedge clk); #1;
    run = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
